// File: rtl/pair_sum_16bit.sv
// Pairs consecutive samples from a valid/ready stream and emits their sum with carry flag.
// Build option: define SUM_SAT_EN to saturate out_data on carry instead of wrapping.
`timescale 1ns/1ps
module pair_sum_16bit #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned CNT_W = 8
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_flush,
  input  logic [WIDTH-1:0] i_in_data,
  input  logic             i_in_valid,
  output logic             o_in_ready,
  output logic [WIDTH-1:0] o_out_data,
  output logic             o_out_valid,
  input  logic             i_out_ready,
  output logic             o_out_ovf,
  output logic [CNT_W-1:0] o_pair_cnt
);

  typedef enum logic [1:0] {StEmpty, StOne, StFull} state_e;

  state_e           r_state;
  state_e           w_state_d;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_data;
  logic             r_ovf;
  logic [CNT_W-1:0] r_cnt;
  logic             w_in_xfer;
  logic             w_out_xfer;
  logic [WIDTH:0]   w_sum;
  logic [WIDTH-1:0] w_sum_data;

  assign w_in_xfer  = i_in_valid & o_in_ready;
  // Flush suppresses the output transfer so the counter cannot advance.
  assign w_out_xfer = o_out_valid & i_out_ready & ~i_flush;
  assign w_sum      = {1'b0, r_a} + {1'b0, i_in_data};

`ifdef SUM_SAT_EN
  assign w_sum_data = w_sum[WIDTH] ? {WIDTH{1'b1}} : w_sum[WIDTH-1:0];
`else
  assign w_sum_data = w_sum[WIDTH-1:0];
`endif

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= StEmpty;
    end else begin
      r_state <= w_state_d;
    end
  end

  always_comb begin
    w_state_d = r_state;
    if (i_flush) begin
      w_state_d = StEmpty;
    end else begin
      unique case (r_state)
        StEmpty: if (w_in_xfer) w_state_d = StOne;
        StOne:   if (w_in_xfer) w_state_d = StFull;
        StFull:  if (w_out_xfer) w_state_d = w_in_xfer ? StOne : StEmpty;
        default: w_state_d = StEmpty;
      endcase
    end
  end

  always_comb begin
    o_in_ready  = i_rst_n & ~i_flush & ((r_state != StFull) | i_out_ready);
    o_out_valid = (r_state == StFull);
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_a    <= '0;
      r_data <= '0;
      r_ovf  <= 1'b0;
      r_cnt  <= '0;
    end else begin
      // In StFull an accepted sample always coincides with the drain, so it starts a new pair.
      if (w_in_xfer && (r_state != StOne)) begin
        r_a <= i_in_data;
      end
      if (i_flush) begin
        r_ovf <= 1'b0;
      end else if (w_in_xfer && (r_state == StOne)) begin
        r_data <= w_sum_data;
        r_ovf  <= w_sum[WIDTH];
      end
      if (w_out_xfer) begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  assign o_out_data = r_data;
  assign o_out_ovf  = r_ovf;
  assign o_pair_cnt = r_cnt;

endmodule
